// File: rtl/fs4_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side and the slave (the datapath) drives the result side.
interface fs4_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
    );
endinterface

// File: rtl/fs4_serial.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Operands are captured when start is accepted; Diff/Bout update only at completion.
module fs4_serial #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fs4_serial_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   d_sr_q, d_sr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               bit_d;
    logic               br_next;

    // One full-subtractor slice operating on the current LSBs.
    always_comb begin
        bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
        br_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.A;
                    b_sr_d  = bus.B;
                    br_d    = bus.Bin;
                    d_sr_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = {bit_d, d_sr_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last bit: publish the result including the bit formed this cycle.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = {bit_d, d_sr_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
endmodule

// File: doc/fs4_serial.md
Name: fs4_serial

Overview:
- Bit-serial N-bit subtractor; the inverse operation of the fa4 ripple adder. Computes Diff = A - B - Bin with a borrow-out.
- Processes one bit per clock, LSB first, under a start/busy/done handshake.
- Used to recover an adder operand from fa4 results and as the sequential arithmetic unit in the grading datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on the accepting edge
- B  input  WIDTH  subtrahend; captured on the accepting edge
- Bin  input  1  borrow-in; captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; Diff/Bout updated at the same edge
- Diff  output  WIDTH  result register, modulo 2^WIDTH
- Bout  output  1  final borrow; 1 when A < B + Bin (unsigned)

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, Diff=0, Bout=0.
  - Internal shift registers, borrow and counter are cleared.
  - Reset overrides start and any operation in progress; the partial result is discarded and Diff is not updated.
- States are IDLE and SHIFT only. done is a registered pulse, not a separate state.
- IDLE:
  - If start=1 at edge 0: load A into shift register a_sr, B into b_sr, Bin into borrow register br; clear counter.
  - Go to SHIFT; busy=1 after edge 0.
  - If start=0, remain in IDLE.
- SHIFT, at each of edges 1..WIDTH:
  - Bit d = a_sr[0] ^ b_sr[0] ^ br.
  - Next br = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - a_sr and b_sr shift right by 1.
  - d shifts into the MSB of internal d_sr (shift right), so after WIDTH shifts d_sr holds the result LSB-aligned.
  - Counter increments.
- Completion at edge WIDTH (the last bit):
  - Diff <= final d_sr value, including the bit computed at this edge.
  - Bout <= final br.
  - done <= 1, busy <= 0, state returns to IDLE.
  - Latency from the start-accept edge to done high is WIDTH edges; throughput is one operation per WIDTH+1 cycles.
- done is high for exactly one cycle, then clears at the next edge unless reset.
- Diff and Bout hold their values until the next completion or reset. They do not change while busy.
- start while busy=1 is ignored. A, B and Bin may change freely after the accepting edge without affecting the result.
- start=1 in the cycle where done=1 (the FSM is already in IDLE) is accepted. done clears at that edge and busy rises.
- start held high continuously produces back-to-back operations, one per WIDTH+1 cycles.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. Bout is the borrow out of the MSB.
- Invariant: {Bout, Diff} == ({1'b0,A} - {1'b0,B} - Bin) mod 2^(WIDTH+1), with Bout the sign bit.

Test Plan:
- A=0000, B=0000, Bin=0, start pulse -> done pulse exactly 4 edges after accept; Diff=0000, Bout=0; busy high for 4 cycles.
- A=0000, B=0000, Bin=1 -> Diff=1111, Bout=1. A=1111, B=1111, Bin=1 -> Diff=1111, Bout=1 (all-borrow ripple).
- A=1010, B=0100, Bin=0 -> Diff=0110, Bout=0. A=0101, B=1010, Bin=0 -> Diff=1011, Bout=1.
- Round trip with an fa4 result: A=1001, B=1110, Bin=0 -> Diff=1011, Bout=1, which recovers fa4 operand A=1011.
- Robustness, run A=1110, B=0010:
  - Pulse start again at edge 2 and change A/B mid-run -> ignored; Diff=1100, Bout=0, single done.
  - Then start held high -> next run accepted in the done cycle, second done 5 cycles after the first.
- Reset handling:
  - Start A=1000, B=0001; rst=1 at edge 2 -> busy=0, done=0, Diff=0000, Bout=0, no done pulse.
  - Next start with A=1000, B=1001, Bin=1 -> Diff=1110, Bout=1.
